// File: rtl/stage3_seq_num_arbiter_if.sv
// rtl/stage3_seq_num_arbiter_if.sv - request/grant bundle between stage-3 message builders and the sequence arbiter
//
// Purpose: groups the requester-facing and framer-facing signals of the
//          stage-3 sequence number arbiter into one port.
// Signals:
//   req            builders -> arbiter   per-requester request level
//   pause          framer   -> arbiter   backpressure, blocks new grants
//   seq_load       host     -> arbiter   one-cycle counter load pulse
//   seq_load_value host     -> arbiter   value loaded by seq_load
//   grant          arbiter  -> builders  registered one-hot grant pulse
//   grant_valid    arbiter  -> framer    OR of grant
//   grant_id       arbiter  -> framer    index of the granted requester
//   grant_seq      arbiter  -> framer    sequence number handed out
//   next_seq       arbiter  -> host      next number to be issued
//   seq_wrap       arbiter  -> host      pulse when the counter wraps to 0
// Modports: master (builders/host/framer side), slave (arbiter side).

interface stage3_seq_num_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int ID_BITS  = 2,
    parameter int SEQ_BITS = 32
);
    logic [NUM_REQ-1:0]  req;
    logic                pause;
    logic                seq_load;
    logic [SEQ_BITS-1:0] seq_load_value;
    logic [NUM_REQ-1:0]  grant;
    logic                grant_valid;
    logic [ID_BITS-1:0]  grant_id;
    logic [SEQ_BITS-1:0] grant_seq;
    logic [SEQ_BITS-1:0] next_seq;
    logic                seq_wrap;

    modport master (
        output req, pause, seq_load, seq_load_value,
        input  grant, grant_valid, grant_id, grant_seq, next_seq, seq_wrap
    );

    modport slave (
        input  req, pause, seq_load, seq_load_value,
        output grant, grant_valid, grant_id, grant_seq, next_seq, seq_wrap
    );
endinterface

// File: rtl/stage3_seq_num_arbiter.sv
// rtl/stage3_seq_num_arbiter.sv - round-robin allocator of the shared stage-3 packet sequence number
//
// Purpose: each cycle picks one pending requester in round-robin order,
//          hands it the current sequence number and increments the counter.
//          Supports a host counter load and a downstream pause.
// Ports:
//   clk    input  clock
//   rst_n  input  synchronous active-low reset
//   bus    slave modport of stage3_seq_num_arbiter_if (req, pause,
//          seq_load, seq_load_value in; grant, grant_valid, grant_id,
//          grant_seq, next_seq, seq_wrap out)

module stage3_seq_num_arbiter #(
    parameter int          NUM_REQ  = 4,
    parameter int          ID_BITS  = 2,
    parameter int          SEQ_BITS = 32,
    parameter int unsigned SEQ_INIT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    stage3_seq_num_arbiter_if.slave  bus
);

    logic [NUM_REQ-1:0]  r_grant;
    logic                r_grant_valid;
    logic [ID_BITS-1:0]  r_grant_id;
    logic [SEQ_BITS-1:0] r_grant_seq;
    logic [SEQ_BITS-1:0] r_next_seq;
    logic                r_seq_wrap;
    logic [ID_BITS-1:0]  r_ptr;

    logic [NUM_REQ-1:0]  w_eligible;
    logic                w_found;
    logic [ID_BITS-1:0]  w_sel;
    logic [ID_BITS-1:0]  w_ptr_next;
    logic [NUM_REQ-1:0]  w_grant_onehot;

    // A requester granted last cycle is masked so its still-high req
    // (it only sees the grant now) cannot win a second time.
    assign w_eligible = bus.req & ~r_grant;

    // Round-robin pick: the first pass finds the lowest eligible index
    // (the wrap-around winner); the second pass overrides it with the
    // lowest eligible index at or above the pointer, if one exists.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_eligible[j]) begin
                w_found = 1'b1;
                w_sel   = ID_BITS'(j);
            end
        end
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_eligible[j] && (ID_BITS'(j) >= r_ptr)) begin
                w_sel = ID_BITS'(j);
            end
        end
    end

    assign w_ptr_next     = (w_sel == ID_BITS'(NUM_REQ - 1)) ? '0 : (w_sel + ID_BITS'(1));
    assign w_grant_onehot = NUM_REQ'(1) << w_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_grant_seq   <= '0;
            r_next_seq    <= SEQ_BITS'(SEQ_INIT);
            r_seq_wrap    <= 1'b0;
            r_ptr         <= '0;
        end else if (bus.seq_load) begin
            // Load wins over pause and over any pending request.
            r_next_seq    <= bus.seq_load_value;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_seq_wrap    <= 1'b0;
        end else if (!bus.pause && w_found) begin
            r_grant       <= w_grant_onehot;
            r_grant_valid <= 1'b1;
            r_grant_id    <= w_sel;
            r_grant_seq   <= r_next_seq;
            r_next_seq    <= r_next_seq + SEQ_BITS'(1);
            r_seq_wrap    <= (r_next_seq == {SEQ_BITS{1'b1}});
            r_ptr         <= w_ptr_next;
        end else begin
            // Idle: grant_id/grant_seq keep the last issued values.
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_seq_wrap    <= 1'b0;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_id    = r_grant_id;
    assign bus.grant_seq   = r_grant_seq;
    assign bus.next_seq    = r_next_seq;
    assign bus.seq_wrap    = r_seq_wrap;

endmodule

// File: doc/stage3_seq_num_arbiter.md
Name: stage3_seq_num_arbiter

Overview:
- Shares the single packet sequence number counter among NUM_REQ message builders in stage 3.
- Each cycle, a round-robin arbiter picks one pending requester and hands it the current sequence number, then increments the counter.
- Supports a host load/resync of the counter and a pause input driven by downstream backpressure.
- Sits between the stage-3 message builders and the packet framer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_BITS, 2, width of the requester index (at least clog2(NUM_REQ)).
- SEQ_BITS, 32, sequence number width.
- SEQ_INIT, 1, counter value after reset.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous reset, active-low.
- req  input  NUM_REQ  per-requester request level; held high until granted.
- pause  input  1  when high, no grants are issued; requests stay pending.
- seq_load  input  1  one-cycle pulse; loads the counter.
- seq_load_value  input  SEQ_BITS  value loaded by seq_load.
- grant  output  NUM_REQ  one-hot grant pulse, registered.
- grant_valid  output  1  high when any grant bit is high.
- grant_id  output  ID_BITS  index of the granted requester.
- grant_seq  output  SEQ_BITS  sequence number allocated to the granted requester.
- next_seq  output  SEQ_BITS  current counter value (next number to be issued).
- seq_wrap  output  1  one-cycle pulse when the counter wraps to 0.

Behaviour:
- Reset (rst_n low at posedge clk), all registers:
  - grant, grant_valid, grant_id, grant_seq = 0; seq_wrap = 0.
  - next_seq = SEQ_INIT.
  - RR pointer = 0, so requester 0 has highest priority.
  - Previous-grant mask = 0.
- Reset mid-operation: any pending requests are forgotten; no grant appears in the cycle after reset.
- Eligibility at edge t: eligible = req AND NOT grant (a requester granted at edge t-1 is masked at edge t). This absorbs the one-cycle delay before the requester drops req, so no double grant occurs. Consequence: one requester gets at most one grant every 2 cycles.
- Arbitration at edge t, when pause=0, seq_load=0 and eligible is non-zero:
  - Select the first eligible index at or after the pointer, wrapping modulo NUM_REQ.
  - Registered results at t+1: grant[k]=1, grant_valid=1, grant_id=k, grant_seq=next_seq.
  - next_seq increments by 1; pointer = (k+1) mod NUM_REQ.
  - Latency: req rising at edge t gives grant visible after edge t (one clock).
- Idle cycle (no eligible request, or pause=1):
  - grant=0, grant_valid=0.
  - grant_id and grant_seq hold their last values.
  - next_seq and pointer unchanged.
- seq_load=1 at edge t:
  - next_seq = seq_load_value.
  - No grant is issued in that cycle, even with requests pending.
  - Pointer unchanged; seq_wrap=0.
  - seq_load takes priority over pause and over grants.
- Wrap-around: a grant issued with next_seq = 2^SEQ_BITS-1 sets next_seq = 0 and pulses seq_wrap=1 in the same cycle as the grant. Sequence number 0 is a valid number to issue.
- Counter arithmetic: modulo 2^SEQ_BITS, unsigned.
- The counter changes only on grant, load or reset.
- Requester rules (checked by bench assertions):
  - req must stay high until grant.
  - req must be low in the cycle after its grant, unless the requester issues a new request.
  - Dropping req before grant withdraws the request.
- Invariants:
  - grant is one-hot or zero.
  - grant_valid = OR(grant).
  - Each issued grant_seq equals the previous grant_seq + 1 (mod 2^SEQ_BITS), except across a seq_load.

Test Plan:
- Reset, then req=0001 held one cycle -> grant=0001 next cycle, grant_seq=1, grant_id=0, next_seq=2.
- req=1111 continuously reasserted after each grant (pointer=0) -> grant_id sequence 0,1,2,3,0,...; grant_seq 1,2,3,4,5,...; no gaps or duplicates.
- req=0110, pause=1 for 5 cycles, then pause=0 -> no grants during pause, next_seq constant; after release, grant_id=1 then 2 on consecutive cycles.
- seq_load=1 with seq_load_value=0x100 while req=0001 -> no grant in the load cycle, next_seq=0x100; next cycle grant_seq=0x100.
- Load 0xFFFFFFFE, grant twice -> grant_seq 0xFFFFFFFE then 0xFFFFFFFF; seq_wrap=1 on the second grant; next_seq=0.
- rst_n low for one cycle while req=1111 and mid-sequence -> all outputs 0, next_seq=1, pointer=0; first grant after reset goes to requester 0 with grant_seq=1.
